// File: rtl/shared_cnt_pkg.sv
// Shared definitions for the shared-counter scheduler.
//   state_e     : scheduler FSM states
//   OP_INC/LOAD : values of the per-requester op select
//   DW_DEFAULT  : default counter width
package shared_cnt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT  = 2'd1,
    ACK  = 2'd2
  } state_e;

  localparam logic OP_INC  = 1'b0;
  localparam logic OP_LOAD = 1'b1;

  localparam int DW_DEFAULT = 8;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick.
//   req     : request vector
//   ptr     : highest-priority index for this round
//   win     : one-hot winner (all zero when no request)
//   win_idx : binary index of the winner (0 when no request)
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int PW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    ptr,
  output logic [N_REQ-1:0] win,
  output logic [PW-1:0]    win_idx
);

  // Walk upward from ptr with wrap; first set bit wins.
  always_comb begin
    logic found;
    int   idx;
    win     = '0;
    win_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int off = 0; off < N_REQ; off++) begin
      idx = (int'(ptr) + off) % N_REQ;
      if (!found && req[idx]) begin
        found    = 1'b1;
        win[idx] = 1'b1;
        win_idx  = PW'(idx);
      end
    end
  end

endmodule

// File: rtl/shared_cnt_sched.sv
// Round-robin scheduler owning one shared counter.
// Each requester holds req until its ack; the winner's op (load/increment)
// and load value are captured at grant time and committed one cycle later.
//   clk, rstn : clock, async active-low reset
//   req       : per-requester request level
//   load      : per-requester op select (1 = load, 0 = increment)
//   ld_val    : packed load values, slice i for requester i
//   gnt       : registered one-hot grant
//   ack       : registered one-hot completion pulse
//   cnt_q     : shared counter
//   busy      : FSM not in IDLE
// Build option: SHARED_CNT_SAT_EN makes increments saturate at all-ones
// instead of wrapping.
module shared_cnt_sched
  import shared_cnt_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int DW    = DW_DEFAULT
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [N_REQ-1:0]  req,
  input  logic [N_REQ-1:0]  load,
  input  logic [N_REQ*DW-1:0] ld_val,
  output logic [N_REQ-1:0]  gnt,
  output logic [N_REQ-1:0]  ack,
  output logic [DW-1:0]     cnt_q,
  output logic              busy
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_e          state_q;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   sel_q;
  logic            op_q;
  logic [DW-1:0]   val_q;
  logic [DW-1:0]   inc_d;
  logic [N_REQ-1:0] win;
  logic [PW-1:0]   win_idx;

  rr_arbiter #(.N_REQ(N_REQ), .PW(PW)) u_arb (
    .req     (req),
    .ptr     (ptr_q),
    .win     (win),
    .win_idx (win_idx)
  );

`ifdef SHARED_CNT_SAT_EN
  assign inc_d = (cnt_q == {DW{1'b1}}) ? cnt_q : cnt_q + DW'(1);
`else
  assign inc_d = cnt_q + DW'(1);
`endif

  // Last winner drops to lowest priority next round.
  assign ptr_d = (sel_q == PW'(N_REQ - 1)) ? '0 : sel_q + PW'(1);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
      op_q    <= OP_INC;
      val_q   <= '0;
      gnt     <= '0;
      ack     <= '0;
      cnt_q   <= '0;
      busy    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|req) begin
            sel_q   <= win_idx;
            op_q    <= load[win_idx];
            val_q   <= ld_val[win_idx*DW +: DW];
            gnt     <= win;
            busy    <= 1'b1;
            state_q <= GNT;
          end
        end
        GNT: begin
          // Commit regardless of whether req[sel] is still held.
          cnt_q   <= (op_q == OP_LOAD) ? val_q : inc_d;
          ack     <= gnt;
          state_q <= ACK;
        end
        ACK: begin
          gnt     <= '0;
          ack     <= '0;
          busy    <= 1'b0;
          ptr_q   <= ptr_d;
          state_q <= IDLE;
        end
        default: begin
          gnt     <= '0;
          ack     <= '0;
          busy    <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shared_cnt_sched.sv
module tb_shared_cnt_sched;

  logic        clk = 1'b0;
  logic        rstn;
  logic [3:0]  req, load;
  logic [31:0] ld_val;
  logic [3:0]  gnt, ack;
  logic [7:0]  cnt_q;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  shared_cnt_sched dut (
    .clk    (clk),
    .rstn   (rstn),
    .req    (req),
    .load   (load),
    .ld_val (ld_val),
    .gnt    (gnt),
    .ack    (ack),
    .cnt_q  (cnt_q),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  req;
    logic [3:0]  load;
    logic [31:0] ldv;
    logic [3:0]  g;
    logic [3:0]  a;
    logic [7:0]  c;
    logic        b;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] g, input logic [3:0] a,
                         input logic [7:0] c, input logic b);
    chk({tag, ".gnt"},  32'(gnt),   32'(g));
    chk({tag, ".ack"},  32'(ack),   32'(a));
    chk({tag, ".cnt"},  32'(cnt_q), 32'(c));
    chk({tag, ".busy"}, 32'(busy),  32'(b));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full three-cycle operation by one requester, dropping req on ack.
  task automatic op(input int idx, input logic ld, input logic [7:0] v,
                    input logic [7:0] c_before, input logic [7:0] c_after, input string tag);
    logic [3:0] m;
    m = 4'(1 << idx);
    req = m;
    load = ld ? m : 4'b0;
    ld_val = '0;
    ld_val[idx*8 +: 8] = v;
    tick(); chk_all({tag, ".g"}, m, 4'b0, c_before, 1'b1);
    tick(); chk_all({tag, ".a"}, m, m, c_after, 1'b1);
    req = '0; load = '0;
    tick(); chk_all({tag, ".i"}, 4'b0, 4'b0, c_after, 1'b0);
  endtask

  initial begin
    // fairness: all four hold, each drops on its own ack
    tbl.push_back(vec_t'{4'b1111, 4'b0, 32'h0, 4'b0001, 4'b0000, 8'd0, 1'b1});
    tbl.push_back(vec_t'{4'b1111, 4'b0, 32'h0, 4'b0001, 4'b0001, 8'd1, 1'b1});
    tbl.push_back(vec_t'{4'b1110, 4'b0, 32'h0, 4'b0000, 4'b0000, 8'd1, 1'b0});
    tbl.push_back(vec_t'{4'b1110, 4'b0, 32'h0, 4'b0010, 4'b0000, 8'd1, 1'b1});
    tbl.push_back(vec_t'{4'b1110, 4'b0, 32'h0, 4'b0010, 4'b0010, 8'd2, 1'b1});
    tbl.push_back(vec_t'{4'b1100, 4'b0, 32'h0, 4'b0000, 4'b0000, 8'd2, 1'b0});
    tbl.push_back(vec_t'{4'b1100, 4'b0, 32'h0, 4'b0100, 4'b0000, 8'd2, 1'b1});
    tbl.push_back(vec_t'{4'b1100, 4'b0, 32'h0, 4'b0100, 4'b0100, 8'd3, 1'b1});
    tbl.push_back(vec_t'{4'b1000, 4'b0, 32'h0, 4'b0000, 4'b0000, 8'd3, 1'b0});
    tbl.push_back(vec_t'{4'b1000, 4'b0, 32'h0, 4'b1000, 4'b0000, 8'd3, 1'b1});
    tbl.push_back(vec_t'{4'b1000, 4'b0, 32'h0, 4'b1000, 4'b1000, 8'd4, 1'b1});
    tbl.push_back(vec_t'{4'b0000, 4'b0, 32'h0, 4'b0000, 4'b0000, 8'd4, 1'b0});
    // pointer wrap: after 3 served, 0 beats 3
    tbl.push_back(vec_t'{4'b1001, 4'b0, 32'h0, 4'b0001, 4'b0000, 8'd4, 1'b1});
    tbl.push_back(vec_t'{4'b1001, 4'b0, 32'h0, 4'b0001, 4'b0001, 8'd5, 1'b1});
    tbl.push_back(vec_t'{4'b1000, 4'b0, 32'h0, 4'b0000, 4'b0000, 8'd5, 1'b0});
    tbl.push_back(vec_t'{4'b1000, 4'b0, 32'h0, 4'b1000, 4'b0000, 8'd5, 1'b1});
    tbl.push_back(vec_t'{4'b1000, 4'b0, 32'h0, 4'b1000, 4'b1000, 8'd6, 1'b1});
    tbl.push_back(vec_t'{4'b0000, 4'b0, 32'h0, 4'b0000, 4'b0000, 8'd6, 1'b0});
    // requester 1 loads 0x05, then increments to 0x06
    tbl.push_back(vec_t'{4'b0010, 4'b0010, 32'h0000_0500, 4'b0010, 4'b0000, 8'd6, 1'b1});
    tbl.push_back(vec_t'{4'b0010, 4'b0010, 32'h0000_0500, 4'b0010, 4'b0010, 8'h05, 1'b1});
    tbl.push_back(vec_t'{4'b0000, 4'b0000, 32'h0, 4'b0000, 4'b0000, 8'h05, 1'b0});
    tbl.push_back(vec_t'{4'b0010, 4'b0000, 32'h0, 4'b0010, 4'b0000, 8'h05, 1'b1});
    tbl.push_back(vec_t'{4'b0010, 4'b0000, 32'h0, 4'b0010, 4'b0010, 8'h06, 1'b1});
    tbl.push_back(vec_t'{4'b0000, 4'b0000, 32'h0, 4'b0000, 4'b0000, 8'h06, 1'b0});

    rstn = 1'b0; req = '0; load = '0; ld_val = '0;
    #12;
    chk_all("reset", 4'b0, 4'b0, 8'h00, 1'b0);
    rstn = 1'b1;
    tick();
    chk_all("idle0", 4'b0, 4'b0, 8'h00, 1'b0);

    for (int i = 0; i < tbl.size(); i++) begin
      req = tbl[i].req; load = tbl[i].load; ld_val = tbl[i].ldv;
      tick();
      chk_all($sformatf("vec%0d", i), tbl[i].g, tbl[i].a, tbl[i].c, tbl[i].b);
    end

    // async reset while in GNT (ptr is 2 here, so 1 wins)
    req = 4'b0010; load = '0; ld_val = '0;
    tick(); chk_all("prerst", 4'b0010, 4'b0, 8'h06, 1'b1);
    #2 rstn = 1'b0;
    #1 chk_all("rst_async", 4'b0, 4'b0, 8'h00, 1'b0);
    tick(); chk_all("rst_hold", 4'b0, 4'b0, 8'h00, 1'b0);
    // ptr must restart at 0: with the old ptr, 3 would win here
    rstn = 1'b1; req = 4'b1001;
    tick(); chk_all("post_rst.g", 4'b0001, 4'b0, 8'h00, 1'b1);
    tick(); chk_all("post_rst.a", 4'b0001, 4'b0001, 8'h01, 1'b1);
    req = '0;
    tick(); chk_all("post_rst.i", 4'b0, 4'b0, 8'h01, 1'b0);

    // requester 2 loads 0xA5 and withdraws during GNT; late ld_val change ignored
    req = 4'b0100; load = 4'b0100; ld_val = 32'h00A5_0000;
    tick(); chk_all("wd.g", 4'b0100, 4'b0, 8'h01, 1'b1);
    req = '0; load = '0; ld_val = 32'h0011_0000;
    tick(); chk_all("wd.a", 4'b0100, 4'b0100, 8'hA5, 1'b1);
    tick(); chk_all("wd.i", 4'b0, 4'b0, 8'hA5, 1'b0);
    op(1, 1'b0, 8'h00, 8'hA5, 8'hA6, "inc_a6");

    // overflow
    op(0, 1'b1, 8'hFF, 8'hA6, 8'hFF, "ld_ff");
`ifdef SHARED_CNT_SAT_EN
    op(0, 1'b0, 8'h00, 8'hFF, 8'hFF, "ovf");
`else
    op(0, 1'b0, 8'h00, 8'hFF, 8'h00, "ovf");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
